// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: opcodes, ALU operation codes and the ID/EX
// control bundle, plus the opcode-to-control decode used by the ID stage.
`ifndef ADDRESS_SIZE
`define ADDRESS_SIZE 32
`endif
`ifndef DATA_SIZE
`define DATA_SIZE 32
`endif

package pipeline_pkg;

  typedef logic [5:0] opcode_t;

  localparam opcode_t OP_RTYPE = 6'h00;
  localparam opcode_t OP_ADDI  = 6'h08;
  localparam opcode_t OP_LW    = 6'h23;
  localparam opcode_t OP_SW    = 6'h2B;
  localparam opcode_t OP_BEQ   = 6'h04;
  localparam opcode_t OP_BNE   = 6'h05;
  localparam opcode_t OP_J     = 6'h02;

  localparam logic [3:0] ALU_NOP   = 4'd0;
  localparam logic [3:0] ALU_FUNCT = 4'd1;
  localparam logic [3:0] ALU_ADD   = 4'd2;
  localparam logic [3:0] ALU_SUB   = 4'd3;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src;
    logic       reg_dst;
    logic [3:0] alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  // J is fully resolved in ID, so it carries no work into EX.
  function automatic ctrl_t decode_ctrl(input opcode_t op, input logic ir_zero);
    ctrl_t c;
    c = CTRL_BUBBLE;
    if (!ir_zero) begin
      case (op)
        OP_RTYPE: begin c.reg_write = 1'b1; c.reg_dst = 1'b1; c.alu_op = ALU_FUNCT; end
        OP_ADDI:  begin c.reg_write = 1'b1; c.alu_src = 1'b1; c.alu_op = ALU_ADD; end
        OP_LW:    begin c.reg_write = 1'b1; c.mem_read = 1'b1; c.alu_src = 1'b1; c.alu_op = ALU_ADD; end
        OP_SW:    begin c.mem_write = 1'b1; c.alu_src = 1'b1; c.alu_op = ALU_ADD; end
        OP_BEQ,
        OP_BNE:   c.alu_op = ALU_SUB;
        default:  c = CTRL_BUBBLE;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/decode_if.sv
// IF/ID inputs, writeback port, and the registered ID/EX outputs of decode.
interface decode_if
  import pipeline_pkg::*;
#(
  parameter int ADDRESS_SIZE = `ADDRESS_SIZE,
  parameter int DATA_SIZE    = `DATA_SIZE
);
  logic [ADDRESS_SIZE-1:0] IF_ID_nextPC;
  logic [DATA_SIZE-1:0]    IF_ID_IR;
  logic                    ex_stall_c;
  logic                    mem_stall_c;
  logic                    wb_write_enable;
  logic [4:0]              wb_write_reg;
  logic [DATA_SIZE-1:0]    wb_write_data;

  logic                    id_stall_c;
  logic                    branch_c;
  logic [ADDRESS_SIZE-1:0] branch_pc;
  logic [ADDRESS_SIZE-1:0] ID_EX_nextPC;
  logic [DATA_SIZE-1:0]    ID_EX_rs_data;
  logic [DATA_SIZE-1:0]    ID_EX_rt_data;
  logic [DATA_SIZE-1:0]    ID_EX_imm;
  logic [4:0]              ID_EX_rs;
  logic [4:0]              ID_EX_rt;
  logic [4:0]              ID_EX_rd;
  ctrl_t                   ID_EX_ctrl;

  modport master (
    output IF_ID_nextPC, IF_ID_IR, ex_stall_c, mem_stall_c,
           wb_write_enable, wb_write_reg, wb_write_data,
    input  id_stall_c, branch_c, branch_pc, ID_EX_nextPC, ID_EX_rs_data,
           ID_EX_rt_data, ID_EX_imm, ID_EX_rs, ID_EX_rt, ID_EX_rd, ID_EX_ctrl
  );

  modport slave (
    input  IF_ID_nextPC, IF_ID_IR, ex_stall_c, mem_stall_c,
           wb_write_enable, wb_write_reg, wb_write_data,
    output id_stall_c, branch_c, branch_pc, ID_EX_nextPC, ID_EX_rs_data,
           ID_EX_rt_data, ID_EX_imm, ID_EX_rs, ID_EX_rt, ID_EX_rd, ID_EX_ctrl
  );
endinterface

// File: rtl/regfile.sv
// 32-entry register file, two combinational read ports and one write port;
// a same-cycle write to the addressed register is forwarded to the reader.
module regfile
  import pipeline_pkg::*;
#(
  parameter int DATA_SIZE = `DATA_SIZE
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [4:0]           rs_addr,
  input  logic [4:0]           rt_addr,
  output logic [DATA_SIZE-1:0] rs_data,
  output logic [DATA_SIZE-1:0] rt_data,
  input  logic                 we,
  input  logic [4:0]           wr_addr,
  input  logic [DATA_SIZE-1:0] wr_data
);
  logic [DATA_SIZE-1:0] mem_q [32];
  logic [DATA_SIZE-1:0] mem_d [32];
  logic                 wr_ok;

  always_comb begin
    wr_ok = we && (wr_addr != 5'd0);
    mem_d = mem_q;
    if (wr_ok) mem_d[wr_addr] = wr_data;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  always_comb begin
    rs_data = mem_q[rs_addr];
    if (wr_ok && (wr_addr == rs_addr)) rs_data = wr_data;
    if (rs_addr == 5'd0) rs_data = '0;
    rt_data = mem_q[rt_addr];
    if (wr_ok && (wr_addr == rt_addr)) rt_data = wr_data;
    if (rt_addr == 5'd0) rt_data = '0;
  end
endmodule

// File: rtl/decode.sv
// Instruction decode stage: control decode, load-use/branch hazard stalls,
// branch/jump resolution with one-slot squash, and the ID/EX register.
module decode
  import pipeline_pkg::*;
#(
  parameter int ADDRESS_SIZE = `ADDRESS_SIZE,
  parameter int DATA_SIZE    = `DATA_SIZE
) (
  input logic     clock,
  input logic     reset_n,
  decode_if.slave bus
);
  logic [5:0]              opcode;
  logic [4:0]              rs, rt;
  logic [15:0]             imm16;
  logic [DATA_SIZE-1:0]    rs_data, rt_data;
  ctrl_t                   ctrl_dec;
  logic                    uses_rs, uses_rt, is_branch, is_jump, taken;
  logic                    load_use, branch_haz, down_stall;
  logic [ADDRESS_SIZE-1:0] br_target;

  logic [ADDRESS_SIZE-1:0] next_pc_q, next_pc_d;
  logic [DATA_SIZE-1:0]    rs_data_q, rs_data_d, rt_data_q, rt_data_d, imm_q, imm_d;
  logic [4:0]              rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
  ctrl_t                   ctrl_q, ctrl_d;
  logic                    squash_q, squash_d;
  logic                    id_stall, branch;

  regfile #(.DATA_SIZE(DATA_SIZE)) u_regfile (
    .clock   (clock),
    .reset_n (reset_n),
    .rs_addr (rs),
    .rt_addr (rt),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .we      (bus.wb_write_enable),
    .wr_addr (bus.wb_write_reg),
    .wr_data (bus.wb_write_data)
  );

  always_comb begin
    opcode     = bus.IF_ID_IR[31:26];
    rs         = bus.IF_ID_IR[25:21];
    rt         = bus.IF_ID_IR[20:16];
    imm16      = bus.IF_ID_IR[15:0];
    ctrl_dec   = decode_ctrl(opcode, bus.IF_ID_IR == '0);
    is_branch  = (opcode == OP_BEQ) || (opcode == OP_BNE);
    is_jump    = (opcode == OP_J);
    // Every decoded opcode except J reads rs; J decodes to a bubble ctrl.
    uses_rs    = (ctrl_dec != CTRL_BUBBLE);
    uses_rt    = ((opcode == OP_RTYPE) && uses_rs) || (opcode == OP_SW) || is_branch;
    taken      = is_jump || ((opcode == OP_BEQ) && (rs_data == rt_data))
                         || ((opcode == OP_BNE) && (rs_data != rt_data));
    br_target  = bus.IF_ID_nextPC + {{(ADDRESS_SIZE-16){imm16[15]}}, imm16};
    load_use   = ctrl_q.mem_read && (rt_q != 5'd0) &&
                 ((uses_rs && (rt_q == rs)) || (uses_rt && (rt_q == rt)));
    branch_haz = is_branch && ctrl_q.reg_write && (rd_q != 5'd0) &&
                 ((rd_q == rs) || (rd_q == rt));
    down_stall = bus.ex_stall_c || bus.mem_stall_c;
  end

  always_comb begin
    next_pc_d = next_pc_q;
    rs_data_d = rs_data_q;
    rt_data_d = rt_data_q;
    imm_d     = imm_q;
    rs_d      = rs_q;
    rt_d      = rt_q;
    rd_d      = rd_q;
    ctrl_d    = ctrl_q;
    squash_d  = squash_q;
    id_stall  = 1'b0;
    branch    = 1'b0;
    if (!down_stall) begin
      if (squash_q || load_use || branch_haz) begin
        next_pc_d = '0;
        rs_data_d = '0;
        rt_data_d = '0;
        imm_d     = '0;
        rs_d      = '0;
        rt_d      = '0;
        rd_d      = '0;
        ctrl_d    = CTRL_BUBBLE;
        squash_d  = 1'b0;
        id_stall  = !squash_q;
      end else begin
        next_pc_d = bus.IF_ID_nextPC;
        rs_data_d = rs_data;
        rt_data_d = rt_data;
        imm_d     = {{(DATA_SIZE-16){imm16[15]}}, imm16};
        rs_d      = rs;
        rt_d      = rt;
        rd_d      = ctrl_dec.reg_dst ? bus.IF_ID_IR[15:11] : rt;
        ctrl_d    = ctrl_dec;
        branch    = taken;
        squash_d  = taken;
      end
    end
  end

  // ID/EX register boundary
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      next_pc_q <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
      ctrl_q    <= CTRL_BUBBLE;
      squash_q  <= 1'b0;
    end else begin
      next_pc_q <= next_pc_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      imm_q     <= imm_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      rd_q      <= rd_d;
      ctrl_q    <= ctrl_d;
      squash_q  <= squash_d;
    end
  end

  assign bus.id_stall_c    = id_stall;
  assign bus.branch_c      = branch;
  assign bus.branch_pc     = is_jump ? {bus.IF_ID_nextPC[ADDRESS_SIZE-1:26], bus.IF_ID_IR[25:0]}
                                     : br_target;
  assign bus.ID_EX_nextPC  = next_pc_q;
  assign bus.ID_EX_rs_data = rs_data_q;
  assign bus.ID_EX_rt_data = rt_data_q;
  assign bus.ID_EX_imm     = imm_q;
  assign bus.ID_EX_rs      = rs_q;
  assign bus.ID_EX_rt      = rt_q;
  assign bus.ID_EX_rd      = rd_q;
  assign bus.ID_EX_ctrl    = ctrl_q;
endmodule

// File: doc/decode.md
DECODE -- requirements
Module: decode

Interface
REQ-001 Parameters: ADDRESS_SIZE, default `ADDRESS_SIZE (32), PC width; DATA_SIZE, default `DATA_SIZE (32), instruction/data width.
REQ-002 clock  input  1  single clock; all state on rising edge.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 IF_ID_nextPC  input  ADDRESS_SIZE  PC of instruction in IF/ID (word-addressed).
REQ-005 IF_ID_IR  input  DATA_SIZE  instruction in IF/ID.
REQ-006 ex_stall_c, mem_stall_c  input  1 each  downstream stalls; hold ID/EX.
REQ-007 wb_write_enable  input  1; wb_write_reg  input  5; wb_write_data  input  DATA_SIZE  writeback port.
REQ-008 id_stall_c  output  1  decode hazard stall to fetch.
REQ-009 branch_c  output  1; branch_pc  output  ADDRESS_SIZE  taken-branch/jump redirect.
REQ-010 ID_EX_nextPC, ID_EX_rs_data, ID_EX_rt_data, ID_EX_imm  output  ADDRESS_SIZE/DATA_SIZE  registered operands; ID_EX_rs, ID_EX_rt, ID_EX_rd  output  5; ID_EX_ctrl  output  ctrl_t  control bundle.

Function
REQ-011 Decoded opcodes: R-type 0x00, ADDI 0x08, LW 0x23, SW 0x2B, BEQ 0x04, BNE 0x05, J 0x02; any other opcode decodes as bubble (all ctrl bits 0).
REQ-012 ctrl_t fields: reg_write, mem_read, mem_write, alu_src, reg_dst, alu_op[3:0]; IR 0x00000000 is a bubble.
REQ-013 ID_EX_imm = sign-extended IR[15:0]; ID_EX_rd = IR[15:11] if reg_dst else IR[20:16].
REQ-014 Register file: 32x DATA_SIZE, two combinational read ports, one write port; register 0 reads 0, writes to it ignored.
REQ-015 Write-through: wb_write_enable with wb_write_reg == rs/rt (nonzero) in the same cycle returns wb_write_data on that read.
REQ-016 Load-use hazard: ID_EX_ctrl.mem_read=1 and ID_EX_rt nonzero equals IR rs, or rt for R-type/SW/BEQ/BNE -> id_stall_c=1 that cycle, ID/EX loads bubble.
REQ-017 Branch hazard: BEQ/BNE whose rs or rt equals a nonzero ID_EX dest with ID_EX_ctrl.reg_write=1 -> id_stall_c=1, bubble inserted; compare retried next cycle.
REQ-018 id_stall_c combinational, asserted at most until the hazard clears; one-cycle stall for load-use.
REQ-019 BEQ taken when rs_data==rt_data, BNE when unequal; branch_pc = IF_ID_nextPC + sign-extended imm16, truncated to ADDRESS_SIZE, wrap-around permitted.
REQ-020 J: branch_c=1, branch_pc = {IF_ID_nextPC[ADDRESS_SIZE-1:26], IR[25:0]}.
REQ-021 branch_c combinational, never asserted while id_stall_c, ex_stall_c or mem_stall_c is 1.
REQ-022 Squash: branch_c=1 sets flag squash_q; next non-stalled cycle the IF/ID instruction is decoded as bubble, no hazard/branch evaluated, squash_q cleared.
REQ-023 ex_stall_c or mem_stall_c: all ID/EX registers and squash_q hold; id_stall_c masked to 0 for hazard purposes (stall already holds fetch).
REQ-024 Priority per cycle: downstream stall > squash > hazard stall > normal load.
REQ-025 Latency: one cycle from IF/ID to ID/EX outputs; regfile write visible same cycle (REQ-015).

Reset
REQ-026 reset_n low, asynchronously: all ID/EX outputs 0 (bubble), squash_q 0, branch_c 0, id_stall_c 0.
REQ-027 Register file contents reset to 0; reset mid-stall or mid-squash discards that state.

Structure
REQ-028 ctrl_t, opcode constants and alu_op encodings live in shared package pipeline_pkg.
REQ-029 Register file is sub-module regfile (2R1W, write-through); hazard and control decode stay in decode.

Verification
REQ-030 After reset, write r1=5 via WB, ADDI r2,r1,3 (0x20220003) -> ID_EX_rs_data=5, ID_EX_imm=3, ctrl.reg_write=1, alu_src=1.
REQ-031 ID_EX holds LW r3 (mem_read, rt=3); IF_ID_IR ADD r4,r3,r1 -> id_stall_c=1 one cycle, ID_EX bubble, then ADD issued.
REQ-032 r1=r2=7, BEQ r1,r2,+4 at PC 0x10 -> branch_c=1, branch_pc=0x14; next IF/ID instruction becomes bubble.
REQ-033 BNE r1,r1,-2 -> branch_c=0, no squash; same BNE with ex_stall_c=1 -> outputs held, branch_c=0.
REQ-034 WB writes r5=0xDEADBEEF while decoding ADD r6,r5,r0 -> ID_EX_rs_data=0xDEADBEEF, rt_data=0; write to r0 then read -> 0.
REQ-035 Assert reset_n low mid load-use stall -> all outputs 0 immediately, no clock edge required.
